// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams latched operands LSB first through an external 1-bit slice.
// Define SERIAL_ALU_OVF_EN to add the MSB carry-in register and the signed overflow flag.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one slice step per clock, cnt = bit being processed
// DONE  | one-cycle completion, result/flags valid; start here chains straight into RUN
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [2:0]       sel,
  input  logic             cin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_final,
  output logic             overflow,
  output logic             sl_a,
  output logic             sl_b,
  output logic             sl_cin,
  output logic             sl_s0,
  output logic             sl_s1,
  output logic             sl_s2,
  output logic             sl_gin,
  input  logic             sl_out,
  input  logic             sl_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       sel_q;
  logic             cin_q;
  logic             carry_q;
  logic             accept;
  logic             last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    sl_a   = 1'b0;
    sl_b   = 1'b0;
    sl_cin = 1'b0;
    sl_s0  = 1'b0;
    sl_s1  = 1'b0;
    sl_s2  = 1'b0;
    sl_gin = 1'b0;
    case (state)
      RUN: begin
        busy   = 1'b1;
        sl_a   = opa_q[cnt];
        sl_b   = opb_q[cnt];
        sl_cin = (cnt == '0) ? cin_q : carry_q;
        sl_s0  = sel_q[0];
        sl_s1  = sel_q[1];
        sl_s2  = sel_q[2];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // cnt holds at WIDTH-1 on the final step rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      sel_q      <= '0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      result     <= '0;
      cout_final <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      opa_q   <= opa;
      opb_q   <= opb;
      sel_q   <= sel;
      cin_q   <= cin;
      carry_q <= 1'b0;
      result  <= '0;
    end else if (state == RUN) begin
      result[cnt] <= sl_out;
      carry_q     <= sl_cout;
      if (last) cout_final <= sl_cout;
      else      cnt        <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic msb_carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    msb_carry_q <= 1'b0;
    else if (last) msb_carry_q <= sl_cin;
  end

  assign overflow = msb_carry_q ^ cout_final;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: emulates the 1-bit slice, checks directed vectors,
// multi-cycle corner sequences and random add/sub operations against a word-level reference.
module tb_serial_alu_seq;

`ifdef SERIAL_ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] opa, opb;
  logic [2:0]  sel;
  logic        cin, start;
  logic        busy, done, cout_final, overflow;
  logic [31:0] result;
  logic        sl_a, sl_b, sl_cin, sl_s0, sl_s1, sl_s2, sl_gin;
  logic        sl_out, sl_cout;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int trace_bad = 0;
  int mstep = 0;
  bit mon_en = 1'b0;
  logic prev_cout = 1'b0;
  logic [31:0] cur_a, cur_b;
  logic [2:0]  cur_s;
  logic        cur_c;

  serial_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opa(opa), .opb(opb), .sel(sel), .cin(cin), .start(start),
    .busy(busy), .done(done), .result(result), .cout_final(cout_final), .overflow(overflow),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_s0(sl_s0), .sl_s1(sl_s1), .sl_s2(sl_s2),
    .sl_gin(sl_gin), .sl_out(sl_out), .sl_cout(sl_cout)
  );

  always #5 clk = ~clk;

  // 1-bit slice: 000 add, 001 subtract (b inverted), 010 and, 011 or, 100 xor, 101 ~a, 110 b, 111 a
  always_comb begin
    logic bx;
    bx      = sl_s0 ? ~sl_b : sl_b;
    sl_out  = 1'b0;
    sl_cout = 1'b0;
    case ({sl_s2, sl_s1, sl_s0})
      3'b000, 3'b001: begin
        sl_out  = sl_a ^ bx ^ sl_cin;
        sl_cout = (sl_a & bx) | (sl_a & sl_cin) | (bx & sl_cin);
      end
      3'b010:  sl_out = sl_a & sl_b;
      3'b011:  sl_out = sl_a | sl_b;
      3'b100:  sl_out = sl_a ^ sl_b;
      3'b101:  sl_out = ~sl_a;
      3'b110:  sl_out = sl_b;
      default: sl_out = sl_a;
    endcase
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // slice-drive trace: step 0 carry is cin, step k carry is the slice carry seen at step k-1
  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      mstep = 0;
      if (mon_en && {sl_a, sl_b, sl_cin, sl_s0, sl_s1, sl_s2, sl_gin} !== 7'b0) trace_bad++;
    end else begin
      if (mon_en && mstep < 32) begin
        if (sl_cin !== ((mstep == 0) ? cur_c : prev_cout)) trace_bad++;
        if (sl_a !== cur_a[mstep] || sl_b !== cur_b[mstep]) trace_bad++;
        if ({sl_s2, sl_s1, sl_s0} !== cur_s || sl_gin !== 1'b0) trace_bad++;
      end
      prev_cout = sl_cout;
      mstep++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                                 input logic c, output logic [31:0] r, output logic co,
                                 output logic ov);
    logic [32:0] sum;
    logic [31:0] bb;
    co = 1'b0;
    ov = 1'b0;
    case (s)
      3'd0, 3'd1: begin
        bb  = (s == 3'd1) ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        r   = sum[31:0];
        co  = sum[32];
        ov  = OVF_ON && (a[31] == bb[31]) && (r[31] != a[31]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = b;
      default: r = a;
    endcase
  endfunction

  // launch one operation and wait (bounded) for done; edges counts the accept edge too
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                       input logic c, output int edges);
    @(negedge clk);
    opa = a; opb = b; sel = s; cin = c; start = 1'b1;
    cur_a = a; cur_b = b; cur_s = s; cur_c = c;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    while (done !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  s;
    logic        c;
    logic [31:0] r;
    logic        co;
    logic        ov_en;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int edges, d0, t1, t2;
    logic [31:0] er, a, b;
    logic eco, eov, c;
    logic [2:0] s;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0003, 3'd1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0003, 32'h0000_0005, 3'd1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 3'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 1'b0, 32'h00F0_1200, 1'b0, 1'b0};
    vecs[6] = '{32'hA5A5_0000, 32'h0000_5A5A, 3'd3, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'd4, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h1111_1111, 3'd0, 1'b1, 32'h2345_678A, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; opa = '0; opb = '0; sel = '0; cin = 1'b0;
    #12;
    chk("reset_outputs", {busy, done, result, cout_final, overflow}, '0);
    chk("reset_slice", {sl_a, sl_b, sl_cin, sl_s0, sl_s1, sl_s2, sl_gin}, '0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, edges);
      chk($sformatf("vec%0d_latency", i), edges, 33);
      chk($sformatf("vec%0d_result", i), result, vecs[i].r);
      chk($sformatf("vec%0d_cout", i), cout_final, vecs[i].co);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ov_en & OVF_ON);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {done, busy}, 2'b00);
      chk($sformatf("vec%0d_hold", i), {result, cout_final, overflow},
          {vecs[i].r, vecs[i].co, vecs[i].ov_en & OVF_ON});
    end

    // start re-pulsed at RUN cycles 5 and 20 must be ignored
    d0 = done_cnt;
    @(negedge clk);
    opa = 32'h1111_1111; opb = 32'h2222_2222; sel = 3'd0; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 20);
      opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; sel = 3'd4; cin = 1'b1;
      if (done === 1'b1) chk("restart_ignored_result", result, 32'h3333_3333);
    end
    start = 1'b0;
    chk("restart_ignored_done_count", done_cnt - d0, 1);

    // start held through DONE chains straight into the next operation
    @(negedge clk);
    opa = 32'h0000_00FF; opb = 32'h0000_0001; sel = 3'd0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    opa = 32'h8000_0000; opb = 32'h8000_0000;
    t1 = 0; t2 = 0;
    for (int k = 1; k <= 100 && t2 == 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && t1 == 0) begin
        t1 = k;
        chk("b2b_first_result", result, 32'h0000_0100);
        @(posedge clk); #1;
        k++;
        start = 1'b0;
        chk("b2b_direct_run", busy, 1'b1);
      end else if (done === 1'b1) begin
        t2 = k;
        chk("b2b_second_result", {result, cout_final, overflow}, {32'h0, 1'b1, OVF_ON});
      end
    end
    chk("b2b_spacing", t2 - t1, 33);
    start = 1'b0;

    // asynchronous reset mid-RUN discards the operation
    @(negedge clk);
    opa = 32'hDEAD_BEEF; opb = 32'h0123_4567; sel = 3'd0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    d0 = done_cnt;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, done, result, cout_final, overflow}, '0);
    chk("midrun_reset_slice", {sl_a, sl_b, sl_cin, sl_s0, sl_s1, sl_s2, sl_gin}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrun_reset_no_done", done_cnt - d0, 0);
    do_op(32'd3, 32'd4, 3'd0, 1'b0, edges);
    chk("after_reset_latency", edges, 33);
    chk("after_reset_result", result, 32'd7);

    // random add/subtract with slice-drive trace checking
    mon_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      a = $urandom; b = $urandom;
      s = 3'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      if (n % 10 == 0) b = ~a;
      d0 = trace_bad;
      do_op(a, b, s, c, edges);
      ref_op(a, b, s, c, er, eco, eov);
      chk($sformatf("rand%0d_latency", n), edges, 33);
      chk($sformatf("rand%0d_out", n), {result, cout_final, overflow}, {er, eco, eov});
      @(posedge clk); #1;
      chk($sformatf("rand%0d_trace", n), trace_bad - d0, 0);
    end
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports opa and opb, input, WIDTH each, the operands, sampled only when start is accepted.
REQ-005 SHALL have port sel, input, 3, the slice function select, sampled when start is accepted and held for the whole operation.
REQ-006 SHALL have port cin, input, 1, the initial carry-in, sampled when start is accepted.
REQ-007 SHALL have port start, input, 1, the request strobe.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port result, output, WIDTH, the assembled output word.
REQ-011 SHALL have port cout_final, output, 1, the carry out of the MSB step.
REQ-012 SHALL have port overflow, output, 1, the signed overflow flag.
REQ-013 SHALL have slice-drive outputs sl_a, sl_b, sl_cin, sl_s0, sl_s1, sl_s2 and sl_gin, 1 bit each, connected to the 1-bit arithmetic slice.
REQ-014 SHALL have slice-return inputs sl_out and sl_cout, 1 bit each, from the 1-bit arithmetic slice.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-016 SHALL, in IDLE or DONE with start=1, latch opa, opb, sel and cin, clear bit counter and result register, and enter RUN.
REQ-017 SHALL ignore start while in RUN: no relatch, no restart.
REQ-018 SHALL, in RUN, drive sl_a/sl_b = bit[cnt] of the latched operands, LSB first, and sl_s2/sl_s1/sl_s0 = latched sel[2:0].
REQ-019 SHALL drive sl_cin = latched cin on step 0 and the registered sl_cout of the previous step on steps 1..WIDTH-1.
REQ-020 SHALL drive sl_gin = 0 constantly.
REQ-021 SHALL drive all sl_* outputs to 0 outside RUN.
REQ-022 SHALL, on each RUN edge, capture sl_out into result bit[cnt] and sl_cout into the carry register, then increment cnt.
REQ-023 SHALL leave RUN for DONE on the edge that captures step WIDTH-1; the counter does not wrap.
REQ-024 SHALL assert done for exactly the one DONE cycle, then go to IDLE unless start=1 in that cycle (back-to-back: DONE->RUN, no IDLE cycle).
REQ-025 SHALL have latency from the start-accept edge to done high of WIDTH+1 rising edges; busy SHALL be high in RUN only.
REQ-026 SHALL hold result, cout_final and overflow stable from DONE until the next start is accepted.
REQ-027 SHALL set cout_final = sl_cout captured at step WIDTH-1.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-RUN, immediately force state=IDLE, cnt=0, busy=0, done=0, result=0, cout_final=0, overflow=0, all sl_* outputs=0, and all latched operands=0.
REQ-029 SHALL resume accepting start on the first rising edge after rst_n deasserts; an operation in progress at reset is discarded with no done.

Configuration
REQ-030 SHALL, with SERIAL_ALU_OVF_EN defined, register the carry into the MSB step and set overflow = carry_into_msb XOR cout_final at DONE.
REQ-031 SHALL, without SERIAL_ALU_OVF_EN, tie overflow to 0 and omit the MSB-carry register.

Verification
REQ-032 SHALL cover this scenario with the slice in add mode: opa=0xFFFFFFFF, opb=0x00000001, cin=0 -> done after 33 edges, result=0x00000000, cout_final=1, overflow=0.
REQ-033 SHALL cover this scenario with the slice in add mode and SERIAL_ALU_OVF_EN defined: opa=0x7FFFFFFF, opb=0x00000001, cin=0 -> result=0x80000000, cout_final=0, overflow=1; the same stimulus without the macro -> overflow=0.
REQ-034 SHALL cover this scenario: start pulsed again at cycles 5 and 20 of RUN -> ignored, result matches the first operands, exactly one done pulse.
REQ-035 SHALL cover this scenario: start held high through DONE with new operands -> DONE->RUN directly, two done pulses 33 cycles apart, both results correct.
REQ-036 SHALL cover this scenario: rst_n pulsed low at RUN step 10 -> all outputs 0 asynchronously, no done, and a following start=1 with opa=3, opb=4 (add) -> result=7.
REQ-037 SHALL cover this scenario: sl_cin trace compared with a slice model over 100 random add/subtract operations -> step-0 sl_cin=cin, step-k sl_cin=prior sl_cout, zero mismatches.
